// File: rtl/fifo_pkg.sv
// Shared sync_fifo read-side constants and buffer sizing helpers.
// Latency: n/a (compile-time only); backpressure: n/a.
package fifo_pkg;

    localparam int RDLAT_COMB = 0;
    localparam int RDLAT_REG  = 1;

    // One entry per word that can be in flight plus one for the word on show.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

    // sync_fifo RDATA_MODE 0 is the registered-read mode.
    function automatic int rdata_mode_to_rd_latency(input int rdata_mode);
        return (rdata_mode == 0) ? RDLAT_REG : RDLAT_COMB;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer holding popped FIFO words for the output stream.
// Latency: push visible on m_data the next cycle; backpressure: holds m_data while pop is low.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is rounded up to a power of two so the pointer width always fits.
    logic [DATA_WIDTH-1:0] mem [2**PTR_W];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            for (int i = 0; i < 2**PTR_W; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign m_valid = (occ != '0);
    assign m_data  = mem[rptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// sync_fifo read controller presenting popped words as a valid/ready stream.
// Latency: 2 cycles empty-fall to m_valid (RD_LATENCY=1), 1 cycle (RD_LATENCY=0); backpressure: credit-limited reads, no bubbles.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = RDLAT_REG,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W     = OCC_W + 1;

    logic [OCC_W-1:0] occ;
    logic             pop;
    logic             push;
    logic             inflight_cnt;
    logic [SUM_W-1:0] credit_used;

    assign pop = m_valid & m_ready;

    // Only RD_LATENCY 0 and 1 are legal, so the in-flight pipe is at most one tag deep.
    if (RD_LATENCY == RDLAT_COMB) begin : g_comb
        assign push         = fifo_rd_en;
        assign inflight_cnt = 1'b0;
    end else begin : g_reg
        logic inflight;
        always_ff @(posedge clk) begin
            if (rst) begin
                inflight <= 1'b0;
            end else begin
                inflight <= fifo_rd_en;
            end
        end
        assign push         = inflight;
        assign inflight_cnt = inflight;
    end

    // A word leaving this cycle frees its slot for a read issued this cycle.
    assign credit_used = SUM_W'(occ) + SUM_W'(inflight_cnt);
    assign fifo_rd_en  = !rst && !fifo_empty
                      && (credit_used < SUM_W'(BUF_DEPTH) + SUM_W'(pop));

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .OCC_W      (OCC_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .m_valid   (m_valid),
        .m_data    (m_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench: two DUTs (RD_LATENCY 0 and 1) each fed by its own behavioural sync_fifo.
// Index 0 is the combinational-read instance, index 1 the registered-read instance.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_ready = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       load_req = 1'b0;
    int         load_len = 0;

    logic        f_empty [2];
    logic        f_rd_en [2];
    logic        mv      [2];
    logic [7:0]  md      [2];
    logic [15:0] rc      [2];
    logic [7:0]  frd0;
    logic [7:0]  rdq1;

    logic [7:0] fmem [2][64];
    int         fwp  [2];
    int         frp  [2];
    int         fcnt [2];
    logic       uflow [2] = '{1'b0, 1'b0};
    logic       oflow [2] = '{1'b0, 1'b0};

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] exp_b;
    int         got [2] = '{0, 0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(0), .CNT_WIDTH(16)) u_lat0 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[0]), .fifo_rd_data(frd0),
        .fifo_rd_en(f_rd_en[0]), .m_valid(mv[0]), .m_data(md[0]),
        .m_ready(m_ready), .rd_count(rc[0])
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1), .CNT_WIDTH(16)) u_lat1 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[1]), .fifo_rd_data(rdq1),
        .fifo_rd_en(f_rd_en[1]), .m_valid(mv[1]), .m_data(md[1]),
        .m_ready(m_ready), .rd_count(rc[1])
    );

    // Behavioural sync_fifo pair; load_req is a bulk preload of 1..load_len.
    assign f_empty[0] = (fcnt[0] == 0);
    assign f_empty[1] = (fcnt[1] == 0);
    assign frd0       = fmem[0][frp[0]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                fwp[i]  <= 0;
                frp[i]  <= 0;
                fcnt[i] <= 0;
            end else if (load_req) begin
                for (int j = 0; j < load_len; j++) fmem[i][j] <= 8'(j + 1);
                fwp[i]  <= load_len;
                frp[i]  <= 0;
                fcnt[i] <= load_len;
            end else begin
                if (f_rd_en[i] && fcnt[i] == 0) uflow[i] <= 1'b1;
                if (wr_en && fcnt[i] == 64 && !f_rd_en[i]) oflow[i] <= 1'b1;
                if (wr_en && fcnt[i] < 64) begin
                    fmem[i][fwp[i]] <= wr_data;
                    fwp[i] <= (fwp[i] + 1) % 64;
                end
                if (f_rd_en[i] && fcnt[i] != 0) frp[i] <= (frp[i] + 1) % 64;
                fcnt[i] <= fcnt[i] + ((wr_en && fcnt[i] < 64) ? 1 : 0)
                                   - ((f_rd_en[i] && fcnt[i] != 0) ? 1 : 0);
            end
        end
        if (f_rd_en[1]) rdq1 <= fmem[1][frp[1]];
    end

    // Scoreboard: every accepted word must match the next word written to the FIFO.
    always @(negedge clk) begin
        if (!rst) begin
            if (mv[0] && m_ready) begin
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL sb_lat0: got %h, expected nothing (scoreboard empty)", md[0]);
                end else begin
                    exp_b = exp_q0.pop_front();
                    if (md[0] !== exp_b) begin
                        errors++;
                        $display("FAIL sb_lat0: got %h, expected %h", md[0], exp_b);
                    end
                end
                got[0]++;
            end
            if (mv[1] && m_ready) begin
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb_lat1: got %h, expected nothing (scoreboard empty)", md[1]);
                end else begin
                    exp_b = exp_q1.pop_front();
                    if (md[1] !== exp_b) begin
                        errors++;
                        $display("FAIL sb_lat1: got %h, expected %h", md[1], exp_b);
                    end
                end
                got[1]++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        wr_en = 1'b0;
        load_req = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input int n);
        load_len = n;
        load_req = 1'b1;
        for (int j = 0; j < n; j++) begin
            exp_q0.push_back(8'(j + 1));
            exp_q1.push_back(8'(j + 1));
        end
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        exp_q0.push_back(d);
        exp_q1.push_back(d);
    endtask

    task automatic wait_drain(input string name);
        int c;
        for (c = 0; c < 60 && (exp_q0.size() != 0 || exp_q1.size() != 0); c++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: words left lat0=%0d lat1=%0d, required 0",
                     name, exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (f_rd_en[i] !== 1'b0 || mv[i] !== 1'b0 || md[i] !== 8'h00 || rc[i] !== 16'd0) begin
                errors++;
                $display("FAIL reset_vals lat%0d: rd_en=%b valid=%b data=%h count=%0d, required 0/0/00/0",
                         i, f_rd_en[i], mv[i], md[i], rc[i]);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (f_rd_en[i] !== 1'b0 || mv[i] !== 1'b0) begin
                errors++;
                $display("FAIL idle_empty lat%0d: rd_en=%b valid=%b, required 0/0", i, f_rd_en[i], mv[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming(input int lat);
        logic exp_v;
        int   g;
        do_reset();
        m_ready = 1'b1;
        g = got[lat];
        load(10);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (f_rd_en[lat] !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_first_rd lat%0d: rd_en=%b, required 1", lat, f_rd_en[lat]);
                end
            end
            exp_v = (k >= lat + 1) && (k <= lat + 10);
            checks++;
            if (mv[lat] !== exp_v) begin
                errors++;
                $display("FAIL stream_valid lat%0d k=%0d: got %b, required %b", lat, k, mv[lat], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (md[lat] !== 8'(k - lat)) begin
                    errors++;
                    $display("FAIL stream_data lat%0d k=%0d: got %h, required %h", lat, k, md[lat], 8'(k - lat));
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rc[lat] !== 16'd10 || got[lat] - g != 10 || uflow[lat] !== 1'b0) begin
            errors++;
            $display("FAIL stream_totals lat%0d: count=%0d delivered=%0d underflow=%b, required 10/10/0",
                     lat, rc[lat], got[lat] - g, uflow[lat]);
        end
    endtask

    task automatic test_concurrent();
        int g [2];
        do_reset();
        g[0] = got[0];
        g[1] = got[1];
        for (int i = 0; i < 10; i++) begin
            write_word(8'(i + 1));
            if (i == 1) m_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        wait_drain("concurrent");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rc[i] !== 16'd10 || got[i] - g[i] != 10 || uflow[i] !== 1'b0 || oflow[i] !== 1'b0) begin
                errors++;
                $display("FAIL concurrent_totals lat%0d: count=%0d delivered=%0d uflow=%b oflow=%b, required 10/10/0/0",
                         i, rc[i], got[i] - g[i], uflow[i], oflow[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int   reads [2];
        logic exp_v;
        do_reset();
        reads[0] = 0;
        reads[1] = 0;
        load(8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (f_rd_en[i]) reads[i]++;
                exp_v = (k >= i + 1);
                checks++;
                if (mv[i] !== exp_v || (exp_v && md[i] !== 8'h01)) begin
                    errors++;
                    $display("FAIL stall_hold lat%0d k=%0d: valid=%b data=%h, required %b/01",
                             i, k, mv[i], md[i], exp_v);
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (reads[i] != i + 1) begin
                errors++;
                $display("FAIL stall_reads lat%0d: got %0d reads, required %0d", i, reads[i], i + 1);
            end
        end
        m_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (mv[i] !== 1'b1 || md[i] !== 8'(j + 1)) begin
                    errors++;
                    $display("FAIL release_b2b lat%0d j=%0d: valid=%b data=%h, required 1/%h",
                             i, j, mv[i], md[i], 8'(j + 1));
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rc[i] !== 16'd8) begin
                errors++;
                $display("FAIL release_count lat%0d: got %0d, required 8", i, rc[i]);
            end
        end
    endtask

    task automatic test_alternating();
        int g [2];
        do_reset();
        g[0] = got[0];
        g[1] = got[1];
        load(6);
        for (int k = 0; k < 30; k++) begin
            m_ready = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        wait_drain("alternating");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rc[i] !== 16'd6 || got[i] - g[i] != 6) begin
                errors++;
                $display("FAIL alt_totals lat%0d: count=%0d delivered=%0d, required 6/6",
                         i, rc[i], got[i] - g[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int g [2];
        do_reset();
        m_ready = 1'b1;
        load(10);
        for (c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rc[1] == 16'd3) break;
        end
        checks++;
        if (c == 30) begin
            errors++;
            $display("FAIL midrst_timeout: rd_count=%0d after 30 cycles, required 3", rc[1]);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ready = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        g[0] = got[0];
        g[1] = got[1];
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mv[i] !== 1'b0 || rc[i] !== 16'd0 || f_rd_en[i] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_state lat%0d: valid=%b count=%0d rd_en=%b, required 0/0/0",
                         i, mv[i], rc[i], f_rd_en[i]);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        write_word(8'hA0);
        @(posedge clk);
        #1;
        write_word(8'hA1);
        @(posedge clk);
        #1 wr_en = 1'b0;
        wait_drain("midrst");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rc[i] !== 16'd2 || got[i] - g[i] != 2) begin
                errors++;
                $display("FAIL midrst_after lat%0d: count=%0d delivered=%0d, required 2/2",
                         i, rc[i], got[i] - g[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming(1);
        test_concurrent();
        test_backpressure();
        test_alternating();
        test_streaming(0);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side controller for the team's `sync_fifo`. It drives the FIFO's `rd_en` and `empty`/`rd_data` port group and presents the popped words as a valid/ready stream to a downstream consumer. It hides the FIFO's read latency with a small credit-tracked skid buffer, so the consumer sees zero-bubble, back-pressurable data. The FIFO is never read while empty, so its `underflow` can never fire.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the attached FIFO.
- `RD_LATENCY`, default 1: cycles from `fifo_rd_en` to valid `fifo_rd_data`. Legal values are 0 (combinational read) and 1 (registered read).
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_rd_data`  in  DATA_WIDTH: FIFO read data.
- `fifo_rd_en`  out  1: FIFO read strobe.
- `m_valid`  out  1: output word valid.
- `m_data`  out  DATA_WIDTH: output word.
- `m_ready`  in  1: consumer accepts the word.
- `rd_count`  out  CNT_WIDTH: number of words handed off; wraps modulo 2^CNT_WIDTH.

## Operation
- **Buffer.** `BUF_DEPTH = RD_LATENCY + 1` entries, organised as a circular buffer with a write pointer, a read pointer and an occupancy count `occ` (0..BUF_DEPTH).
- **In-flight tracking.** `inflight` is a shift register of length RD_LATENCY that tags each issued read. With RD_LATENCY=0 it does not exist and is treated as 0.
- **Pop.** `pop = m_valid & m_ready`.
- **Issue rule.** `fifo_rd_en = !rst & !fifo_empty & (occ + inflight_cnt - pop < BUF_DEPTH)`.
  - `fifo_rd_en` is combinational from `m_ready`.
  - It is never asserted while `fifo_empty` = 1.
- **Capture.** A word is written into the buffer on the edge where its tag exits the in-flight pipe. For RD_LATENCY=0 that is the same edge as `fifo_rd_en`; for RD_LATENCY=1 it is the next edge.
- **Output.** `m_valid = (occ != 0)` and `m_data = buf[rptr]`, both driven from registers only.
- **Count.** `rd_count` increments by 1 on every `pop`.
- **Simultaneous capture and pop.** `occ` is unchanged; both pointers advance.
- **Back-pressure.** While `m_valid` = 1 and `m_ready` = 0:
  - `m_data` stays stable;
  - `m_valid` does not drop;
  - issue stops once buffer plus in-flight words total BUF_DEPTH.
- **Credit accounting.** Buffer plus in-flight words can never exceed BUF_DEPTH, so there is no overflow path.
- **FIFO goes empty.** Issue stops. Words already in flight are still captured and delivered.

## Timing
- **Reset values.** `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `rd_count` = 0. Pointers, `occ` and the in-flight tags are cleared.
- **Reset mid-operation.** In-flight and buffered words are discarded. The FIFO is reset with the same `rst`, so no words are silently lost from a live FIFO.
- **Latency with RD_LATENCY=1.**
  - `fifo_empty` falls in cycle t, so `fifo_rd_en` = 1 in cycle t.
  - The data is captured at the end of t+1.
  - `m_valid` = 1 in cycle t+2.
- **Latency with RD_LATENCY=0.** `m_valid` = 1 in cycle t+1.
- **Throughput.** With `m_ready` held high and the FIFO non-empty, the block delivers one word per cycle with no bubbles, for either RD_LATENCY.
- **Ordering.** Output order equals FIFO order. No duplicated words, no dropped words.

## Structure
- **Shared package `fifo_pkg`.**
  - Constants `RDLAT_COMB` = 0 and `RDLAT_REG` = 1.
  - The `BUF_DEPTH` derivation, shared with `sync_fifo`'s RDATA_MODE mapping: RDATA_MODE 0 maps to RD_LATENCY 1.
- **Sub-module `fifo_rd_skid_buf`.** BUF_DEPTH-entry circular buffer with push, pop, `occ`, `m_valid` and `m_data`.
- **Top level.** Holds the issue logic, the in-flight pipe and `rd_count`.

## Test plan
1. **Streaming, RD_LATENCY=1.** Preload 1..10 into `sync_fifo` and hold `m_ready`=1.
   - Required: `m_data` = 1..10 on 10 consecutive cycles, first one 2 cycles after `fifo_empty` falls.
   - Required: `rd_count` = 10 and `fifo_rd_en` never high while empty.
2. **Concurrent write, staggered start.** Write 1..10 at one per cycle while `m_ready` rises 1 cycle after reset release (the `tb_sync_fifo` pattern).
   - Required: all 10 words delivered in order.
   - Required: FIFO `underflow` and `overflow` never assert.
3. **Back-pressure.** Preload 1..8, hold `m_ready`=0 for 5 cycles, then set it to 1.
   - Required: `m_valid`=1 with `m_data`=1 stable throughout the stall.
   - Required: exactly 2 FIFO reads issued during the stall, then 1..8 delivered back-to-back.
4. **Alternating ready.** Toggle `m_ready` 1,0,1,0 on words 1..6.
   - Required: every accepted word is correct and in order, and `rd_count` = 6.
5. **Combinational read.** Repeat scenario 1 with RD_LATENCY=0.
   - Required: first `m_valid` 1 cycle after `fifo_empty` falls; 1..10 with no bubbles.
6. **Reset mid-stream.** Assert `rst` for 1 cycle after 3 words are delivered.
   - Required: the next cycle shows `m_valid`=0, `rd_count`=0 and `fifo_rd_en`=0.
   - Required: new writes 0xA0, 0xA1 are delivered correctly afterwards.
